// File: rtl/cache_word_replacer_pkg.sv
// Shared cache constants: line geometry and metadata field positions.
// The merge datapath imports only the widths.
package cache_word_replacer_pkg;

  localparam int LINE_BITS = 512;
  localparam int WORD_BITS = 32;
  localparam int OFF_BITS  = 4;

  // Metadata sits directly above the data bits of a stored line
  localparam int META_VALID_BIT = 536;
  localparam int META_DIRTY_BIT = 535;
  localparam int META_LRU_HI    = 534;
  localparam int META_LRU_LO    = 533;
  localparam int META_TAG_HI    = 532;
  localparam int META_TAG_LO    = 512;

endpackage

// File: rtl/cache_word_replacer_word_mux.sv
// Combinational 2**OFF_W-to-1 word selector built from a one-hot decode
// and an AND-OR tree, shared with the controller's read-hit path.
module word_mux #(
  parameter int WORD_W = 32,
  parameter int OFF_W  = 4
) (
  input  logic [(2**OFF_W)*WORD_W-1:0] line,
  input  logic [OFF_W-1:0]             sel,
  output logic [WORD_W-1:0]            word
);

  localparam int NWORDS = 2**OFF_W;

  always_comb begin
    word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      word = word
        | (line[k*WORD_W +: WORD_W]
           & {WORD_W{sel == OFF_W'(k)}});
    end
  end

endmodule

// File: rtl/cache_word_replacer.sv
// Single-word merge into a cache line with registered merged line,
// pre-merge word and valid flag.
module cache_word_replacer
  import cache_word_replacer_pkg::*;
#(
  parameter int BLOCK_W = LINE_BITS,
  parameter int WORD_W  = WORD_BITS,
  parameter int OFF_W   = OFF_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic [OFF_W-1:0]   word_offset,
  input  logic [WORD_W-1:0]  data_write,
  output logic [BLOCK_W-1:0] data_out,
  output logic [WORD_W-1:0]  word_out,
  output logic               out_valid
);

  localparam int NWORDS = BLOCK_W / WORD_W;

  if ((BLOCK_W % WORD_W) != 0 || NWORDS != 2**OFF_W) begin : g_cfg_err
    $error("cache_word_replacer: BLOCK_W/WORD_W must equal 2**OFF_W");
  end

  logic [BLOCK_W-1:0] merged;
  logic [WORD_W-1:0]  old_word;

  // Per-word mux driven by a one-hot hit, no variable shifter
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    logic hit;
    assign hit = enable && (word_offset == OFF_W'(k));
    assign merged[k*WORD_W +: WORD_W] =
      hit ? data_write : data_in[k*WORD_W +: WORD_W];
  end

  word_mux #(
    .WORD_W (WORD_W),
    .OFF_W  (OFF_W)
  ) u_word_mux (
    .line (data_in),
    .sel  (word_offset),
    .word (old_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      word_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      data_out  <= merged;
      word_out  <= old_word;
      out_valid <= enable;
    end
  end

endmodule

// File: tb/tb_cache_word_replacer.sv
// Scoreboard bench for cache_word_replacer: directed cases, reset
// behaviour and a random regression against a reference model.
module tb_cache_word_replacer;

  typedef struct {
    logic [511:0] d;
    logic [31:0]  w;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [511:0] data_in;
  logic [3:0]   word_offset;
  logic [31:0]  data_write;
  logic [511:0] data_out;
  logic [31:0]  word_out;
  logic         out_valid;

  exp_t q[$];
  int   total;
  int   bad;

  cache_word_replacer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .data_in     (data_in),
    .word_offset (word_offset),
    .data_write  (data_write),
    .data_out    (data_out),
    .word_out    (word_out),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector between edges, queue its expected result,
  // then return 1 time unit after the sampling edge.
  task automatic drive(input logic [511:0] l, input logic [3:0] o,
                       input logic [31:0] wr, input logic en);
    exp_t e;
    @(negedge clk);
    data_in     = l;
    word_offset = o;
    data_write  = wr;
    enable      = en;
    e.d = l;
    if (en) e.d[o*32 +: 32] = wr;
    e.w = l[o*32 +: 32];
    e.v = en;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    data_in = '1;
    word_offset = 4'd3;
    data_write = '1;
    #1;
    total++;
    if (data_out !== 512'h0 || word_out !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got %h/%h/%b want 0/0/0",
               data_out, word_out, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    logic [511:0] l;
    l = {128{4'hB, 4'hA, 4'hD, 4'hB}};
    drive(l, 4'd4, 32'hDEADBEEF, 1'b1);
    e = q.pop_front();
    total++;
    if (data_out[159:128] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_word4 got %h want deadbeef", data_out[159:128]);
    end
    total++;
    if (data_out !== e.d) begin
      bad++;
      $display("FAIL basic_line got %h want %h", data_out, e.d);
    end
    total++;
    if (word_out !== 32'hBADBBADB) begin
      bad++;
      $display("FAIL basic_word_out got %h want badbbadb", word_out);
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_valid got %b want 1", out_valid);
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    drive(512'h0, 4'd0, 32'hCAFEBABE, 1'b1);
    e = q.pop_front();
    total++;
    if (data_out !== 512'hCAFEBABE || data_out !== e.d) begin
      bad++;
      $display("FAIL offset0 got %h want %h", data_out, e.d);
    end
    drive(512'h0, 4'd15, 32'h11111111, 1'b1);
    e = q.pop_front();
    total++;
    if (data_out !== {32'h11111111, 480'h0} || data_out !== e.d) begin
      bad++;
      $display("FAIL offset15 got %h want %h", data_out, e.d);
    end
    total++;
    if (word_out !== 32'h0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL offset15_side got %h/%b want 0/1", word_out, out_valid);
    end
  endtask

  task automatic test_disabled();
    exp_t e;
    drive(512'hA5, 4'd2, 32'h55555555, 1'b0);
    e = q.pop_front();
    total++;
    if (data_out !== 512'hA5 || data_out !== e.d) begin
      bad++;
      $display("FAIL disabled_line got %h want %h", data_out, e.d);
    end
    total++;
    if (out_valid !== 1'b0 || word_out !== 32'h0) begin
      bad++;
      $display("FAIL disabled_side got %h/%b want 0/0", word_out, out_valid);
    end
    drive(512'hA5, 4'd0, 32'h55555555, 1'b0);
    e = q.pop_front();
    total++;
    if (word_out !== 32'hA5 || word_out !== e.w) begin
      bad++;
      $display("FAIL disabled_word got %h want %h", word_out, e.w);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [511:0] l;
    logic [31:0]  wr [3];
    wr[0] = 32'h22222222;
    wr[1] = 32'h33333333;
    wr[2] = 32'h44444444;
    l = {16{32'hFEEDFACE}};
    for (int i = 0; i < 3; i++) begin
      drive(l, 4'(i + 1), wr[i], 1'b1);
      e = q.pop_front();
      total++;
      if (data_out !== e.d || word_out !== 32'hFEEDFACE || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d got %h/%h/%b want %h/feedface/1",
                 i, data_out, word_out, out_valid, e.d);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive({16{32'h12345678}}, 4'd7, 32'h9ABCDEF0, 1'b1);
    e = q.pop_front();
    total++;
    if (data_out !== e.d || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL prereset got %h/%b want %h/1", data_out, out_valid, e.d);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (data_out !== 512'h0 || word_out !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got %h/%h/%b want 0/0/0",
               data_out, word_out, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive({16{32'h0F0F0F0F}}, 4'd9, 32'hA0A0A0A0, 1'b1);
    e = q.pop_front();
    total++;
    if (data_out !== e.d || word_out !== 32'h0F0F0F0F || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got %h/%h/%b want %h/0f0f0f0f/1",
               data_out, word_out, out_valid, e.d);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [511:0] l;
    int errs;
    errs = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
      drive(l, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      e = q.pop_front();
      total++;
      if (data_out !== e.d || word_out !== e.w || out_valid !== e.v) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_%0d word_out %h want %h valid %b want %b",
                   n, word_out, e.w, out_valid, e.v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_disabled();
    test_back_to_back();
    test_async_reset();
    test_random();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_word_replacer.md
# cache_word_replacer

Single-word merge unit for the data path of the 4-way, 64-byte-line cache controller. On each enabled cycle it takes a full cache line and overwrites one 32-bit word, selected by a word offset, with CPU write data. It returns the merged line and the word that was overwritten. The controller uses it on write hits, where the line comes from the cache array, and on write-allocate fills, where the line comes from memory.

## Interface
Parameters:
- `BLOCK_W`, default 512: line width in bits; must be an exact multiple of `WORD_W`.
- `WORD_W`, default 32: word width in bits.
- `OFF_W`, default 4: offset width; `BLOCK_W/WORD_W` must equal `2**OFF_W`. Any mismatch is an elaboration-time error.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  perform the merge this cycle.
- `data_in`  in  `BLOCK_W`  source cache line.
- `word_offset`  in  `OFF_W`  index of the word to replace.
- `data_write`  in  `WORD_W`  replacement word.
- `data_out`  out  `BLOCK_W`  merged line, registered.
- `word_out`  out  `WORD_W`  pre-merge value of the selected word, registered.
- `out_valid`  out  1  `data_out`/`word_out` hold the result of an enabled cycle.

## Operation
- Word k occupies `data_in[WORD_W*k + WORD_W-1 : WORD_W*k]`. Word 0 is the LSBs; word 15 is bits [511:480].
- When `enable`=1 on a rising edge:
  - `data_out` ← `data_in` with word `word_offset` replaced by `data_write`; all other bits are bit-exact copies of `data_in`.
  - `word_out` ← `data_in` word `word_offset`, i.e. the value before replacement.
  - `out_valid` ← 1.
- When `enable`=0 on a rising edge:
  - `data_out` ← `data_in` unchanged (passthrough).
  - `word_out` ← `data_in` word `word_offset`.
  - `out_valid` ← 0.
- Every offset value is legal, including 0 and `2**OFF_W-1`. There is no wrap-around and no partial-word write.
- No internal state beyond the output registers. Each cycle is independent of previous cycles.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one merge per cycle. Back-to-back enabled cycles are allowed with no bubbles.
- No handshake. The caller holds its inputs stable only around the sampling edge.
- Reset values, asserted asynchronously as soon as `rst_n` falls: `data_out`=0, `word_out`=0, `out_valid`=0.
- Reset mid-operation: an in-flight result is discarded. The first edge after `rst_n` rises samples inputs normally.
- Selection logic is a one-hot decode of `word_offset` into per-word muxes, not a variable shift. This keeps the path depth at log2(16).

## Structure
- Shared cache package holds the line, word and offset constants (512/32/4) and the bit positions of the line-metadata fields used by the controller: valid = 536, dirty = 535, LRU = 534:533, tag = 532:512. This block imports only the widths.
- Sub-module `word_mux`: combinational `2**OFF_W`-to-1 word selector. It is used here for `word_out` and is reusable by the controller's read-hit path.
- The merge itself is a generate loop over words inside this block.

## Test plan
- Line 512'hBADB…ADB (pattern repeated), offset 4, write 32'hDEADBEEF, enable=1 -> after one edge:
  - `data_out[159:128]`=DEADBEEF, all other bits unchanged.
  - `word_out`=word 4 of the input line.
  - `out_valid`=1.
- Boundary offsets on line 512'h0:
  - offset 0, write CAFEBABE -> `data_out`=512'hCAFEBABE.
  - offset 15, write 11111111 -> only bits [511:480]=11111111.
- enable=0, line 512'hA5, offset 2, write 55555555 -> `data_out`=512'hA5, `out_valid`=0.
- Back-to-back enabled cycles with offsets 1, 2, 3 and writes 22222222, 33333333, 44444444 on a constant 512'hFEEDFACE… line -> each result appears exactly one cycle later, and each touches only its own word.
- Assert `rst_n` between edges after an enabled cycle -> outputs go to 0 immediately without a clock edge. After release, the next enabled cycle produces the correct merge.
- Random regression: 10k random line/offset/write/enable vectors against a reference model, checking `data_out`, `word_out` and `out_valid` every cycle.
